// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared widths and constants for the instruction fetch front end
package ifu_pkg;
  localparam int IFU_PC_W    = 32;
  localparam int IFU_INSTR_W = 32;
  localparam int IFU_ERR_W   = 1;
  localparam int IFU_ENTRY_W = IFU_ERR_W + IFU_PC_W + IFU_INSTR_W;
  localparam logic [IFU_INSTR_W-1:0] IFU_INSTR_NOP = 32'h0000_0013;
endpackage

// File: rtl/ifu_fetchq_if.sv
// rtl/ifu_fetchq_if.sv - instruction bus request/response and EXU issue handshakes
interface ifu_fetchq_if
  import ifu_pkg::*;
#(
  parameter int PC_W    = IFU_PC_W,
  parameter int INSTR_W = IFU_INSTR_W
);
  logic               ifu_req_valid;
  logic               ifu_req_ready;
  logic [PC_W-1:0]    ifu_req_pc;
  logic               ifu_rsp_valid;
  logic               ifu_rsp_ready;
  logic [INSTR_W-1:0] ifu_rsp_instr;
  logic               ifu_rsp_err;
  logic               ifu_o_valid;
  logic               ifu_o_ready;
  logic [INSTR_W-1:0] ifu_o_ir;
  logic [PC_W-1:0]    ifu_o_pc;
  logic               ifu_o_err;

  modport master (
    output ifu_req_valid, ifu_req_pc, ifu_rsp_ready, ifu_o_valid, ifu_o_ir, ifu_o_pc, ifu_o_err,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err, ifu_o_ready
  );

  modport slave (
    input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready, ifu_o_valid, ifu_o_ir, ifu_o_pc, ifu_o_err,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err, ifu_o_ready
  );
endinterface

// File: rtl/ifu_fq_fifo.sv
// rtl/ifu_fq_fifo.sv - synchronous FIFO with combinational head, occupancy count and clear
module ifu_fq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clr,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_wdata,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  // Explicit wrap keeps non-power-of-two depths (e.g. shadow of 3) correct.
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_push  = i_push & (r_cnt != FULL_C);
  assign w_pop   = i_pop & (r_cnt != '0);
  assign o_rdata = r_mem[r_rd];
  assign o_count = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_wdata;
        r_wr        <= nxt(r_wr);
      end
      if (w_pop) r_rd <= nxt(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/ifu_fetchq.sv
// rtl/ifu_fetchq.sv - fetch front end: sequential PC generator, outstanding tracker, fetch queue
module ifu_fetchq
  import ifu_pkg::*;
#(
  parameter int PC_W     = IFU_PC_W,
  parameter int INSTR_W  = IFU_INSTR_W,
  parameter int FQ_DEPTH = 4,
  parameter int MAX_OUTS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   i_pc_rtvec,
  ifu_fetchq_if.master      bus,
  input  logic              i_pipe_flush_req,
  input  logic [PC_W-1:0]   i_pipe_flush_pc,
  output logic              o_pipe_flush_ack,
  input  logic              i_ifu_halt_req,
  output logic              o_ifu_halt_ack
);
  localparam int OW = $clog2(MAX_OUTS + 1);
  localparam int QW = $clog2(FQ_DEPTH + 1);
  localparam int SW = ((OW > QW) ? OW : QW) + 1;
  localparam int EW = IFU_ERR_W + PC_W + INSTR_W;
  localparam logic [OW-1:0] MAX_OUTS_C = OW'(MAX_OUTS);
  localparam logic [SW-1:0] FQ_DEPTH_C = SW'(FQ_DEPTH);

  logic            r_boot;
  logic [PC_W-1:0] r_pc;
  logic [OW-1:0]   r_outs;
  logic [OW-1:0]   r_kill;

  logic            w_flush;
  logic            w_req_hs;
  logic            w_rsp_hs;
  logic            w_push;
  logic            w_pop;
  logic [OW-1:0]   w_outs_dec;
  logic [QW-1:0]   w_fq_cnt;
  logic [EW-1:0]   w_q_head;
  logic [PC_W-1:0] w_sh_pc;
  logic [OW-1:0]   w_sh_cnt;

  assign w_flush    = i_pipe_flush_req;
  assign w_rsp_hs   = bus.ifu_rsp_valid;
  assign w_req_hs   = bus.ifu_req_valid & bus.ifu_req_ready;
  assign w_push     = w_rsp_hs & (r_kill == '0) & ~w_flush;
  assign w_pop      = bus.ifu_o_valid & bus.ifu_o_ready;
  assign w_outs_dec = r_outs - OW'(w_rsp_hs);

  // Credit: every outstanding request owns a queue slot, so a push never meets a full queue.
  assign bus.ifu_req_valid = ~r_boot & ~i_ifu_halt_req & ~w_flush
                           & (r_outs < MAX_OUTS_C)
                           & ((SW'(r_outs) + SW'(w_fq_cnt)) < FQ_DEPTH_C);
  assign bus.ifu_req_pc    = r_pc;
  assign bus.ifu_rsp_ready = 1'b1;
  assign bus.ifu_o_valid   = (w_fq_cnt != '0) & ~w_flush;
  assign {bus.ifu_o_err, bus.ifu_o_pc, bus.ifu_o_ir} = w_q_head;
  assign o_pipe_flush_ack  = 1'b1;
  assign o_ifu_halt_ack    = i_ifu_halt_req & (r_outs == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_boot <= 1'b1;
      r_pc   <= '0;
      r_outs <= '0;
      r_kill <= '0;
    end else begin
      r_boot <= 1'b0;
      if (w_flush)       r_pc <= i_pipe_flush_pc & ~PC_W'(3);
      else if (r_boot)   r_pc <= i_pc_rtvec;
      else if (w_req_hs) r_pc <= r_pc + PC_W'(4);
      r_outs <= w_outs_dec + OW'(w_req_hs);
      // Everything still in flight after this cycle's response belongs to the old path.
      if (w_flush)                          r_kill <= w_outs_dec;
      else if (w_rsp_hs && r_kill != '0)    r_kill <= r_kill - OW'(1);
    end
  end

  ifu_fq_fifo #(.W(EW), .DEPTH(FQ_DEPTH)) u_fq (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_flush),
    .i_push  (w_push),
    .i_wdata ({bus.ifu_rsp_err, w_sh_pc, bus.ifu_rsp_instr}),
    .i_pop   (w_pop),
    .o_rdata (w_q_head),
    .o_count (w_fq_cnt)
  );

  ifu_fq_fifo #(.W(PC_W), .DEPTH(MAX_OUTS)) u_pc_shadow (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_flush),
    .i_push  (w_req_hs),
    .i_wdata (r_pc),
    .i_pop   (w_push),
    .o_rdata (w_sh_pc),
    .o_count (w_sh_cnt)
  );

  a_rsp_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
    w_rsp_hs |-> (r_outs != '0));
  a_push_has_pc: assert property (@(posedge clk) disable iff (rst)
    w_push |-> (w_sh_cnt != '0));
endmodule

// File: tb/tb_ifu_fetchq.sv
// tb/tb_ifu_fetchq.sv - directed testbench for ifu_fetchq
module tb_ifu_fetchq;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_rtvec;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic        flush_ack;
  logic        halt_req;
  logic        halt_ack;

  always #5 clk = ~clk;

  ifu_fetchq_if bus ();

  ifu_fetchq #(.FQ_DEPTH(4), .MAX_OUTS(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_pc_rtvec       (pc_rtvec),
    .bus              (bus),
    .i_pipe_flush_req (flush_req),
    .i_pipe_flush_pc  (flush_pc),
    .o_pipe_flush_ack (flush_ack),
    .i_ifu_halt_req   (halt_req),
    .o_ifu_halt_ack   (halt_ack)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc, lat, outs_model, max_outs;
  logic [31:0] err_pc;
  logic [31:0] pq[$];
  int          pt[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  int          rsp_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ir[$];
  logic        pop_err[$];
  int          pop_cyc[$];
  logic        s_req_v, s_o_v;

  function automatic logic [31:0] mk_ir(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic clear_logs();
    req_log.delete(); req_cyc.delete(); rsp_cyc.delete();
    pop_pc.delete(); pop_ir.delete(); pop_err.delete(); pop_cyc.delete();
  endtask

  // One clock: in-order bus responder with fixed latency, sample at negedge, update at posedge+1.
  task automatic tick();
    logic        hs;
    logic [31:0] hs_pc;
    if (pq.size() > 0 && (cyc - pt[0]) >= lat) begin
      bus.ifu_rsp_valid = 1'b1;
      bus.ifu_rsp_instr = mk_ir(pq[0]);
      bus.ifu_rsp_err   = (pq[0] == err_pc);
    end else begin
      bus.ifu_rsp_valid = 1'b0;
      bus.ifu_rsp_instr = '0;
      bus.ifu_rsp_err   = 1'b0;
    end
    @(negedge clk);
    s_req_v = bus.ifu_req_valid;
    s_o_v   = bus.ifu_o_valid;
    hs      = s_req_v & bus.ifu_req_ready;
    hs_pc   = bus.ifu_req_pc;
    if (hs) begin req_log.push_back(hs_pc); req_cyc.push_back(cyc); end
    if (s_o_v && bus.ifu_o_ready) begin
      pop_pc.push_back(bus.ifu_o_pc); pop_ir.push_back(bus.ifu_o_ir);
      pop_err.push_back(bus.ifu_o_err); pop_cyc.push_back(cyc);
    end
    if (bus.ifu_rsp_valid) rsp_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    if (bus.ifu_rsp_valid) begin
      void'(pq.pop_front()); void'(pt.pop_front()); outs_model--;
    end
    if (hs) begin pq.push_back(hs_pc); pt.push_back(cyc); outs_model++; end
    if (outs_model > max_outs) max_outs = outs_model;
    cyc++;
  endtask

  task automatic do_reset(input logic [31:0] vec);
    rst = 1'b1; pc_rtvec = vec; flush_req = 1'b0; flush_pc = '0; halt_req = 1'b0;
    pq.delete(); pt.delete(); outs_model = 0; max_outs = 0; clear_logs();
    tick(); tick();
    rst = 1'b0; cyc = 0;
  endtask

  task automatic test_reset();
    bus.ifu_req_ready = 1'b1; bus.ifu_o_ready = 1'b1; lat = 1; err_pc = 32'hFFFF_FFFF; cyc = 0;
    rst = 1'b1; pc_rtvec = 32'h1234_5678; flush_req = 1'b0; flush_pc = '0; halt_req = 1'b0;
    tick(); tick();
    n_total++; if (bus.ifu_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", bus.ifu_req_valid); else n_pass++;
    n_total++; if (bus.ifu_req_pc !== 32'h0) $display("FAIL rst_req_pc: got %h expected 0", bus.ifu_req_pc); else n_pass++;
    n_total++; if (bus.ifu_rsp_ready !== 1'b1) $display("FAIL rst_rsp_ready: got %b expected 1", bus.ifu_rsp_ready); else n_pass++;
    n_total++; if (bus.ifu_o_valid !== 1'b0) $display("FAIL rst_o_valid: got %b expected 0", bus.ifu_o_valid); else n_pass++;
    n_total++; if (bus.ifu_o_ir !== 32'h0) $display("FAIL rst_o_ir: got %h expected 0", bus.ifu_o_ir); else n_pass++;
    n_total++; if (bus.ifu_o_pc !== 32'h0) $display("FAIL rst_o_pc: got %h expected 0", bus.ifu_o_pc); else n_pass++;
    n_total++; if (bus.ifu_o_err !== 1'b0) $display("FAIL rst_o_err: got %b expected 0", bus.ifu_o_err); else n_pass++;
    n_total++; if (flush_ack !== 1'b1) $display("FAIL rst_flush_ack: got %b expected 1", flush_ack); else n_pass++;
    n_total++; if (halt_ack !== 1'b0) $display("FAIL rst_halt_ack: got %b expected 0", halt_ack); else n_pass++;
  endtask

  task automatic test_boot_seq();
    logic [31:0] exp_pc;
    lat = 1; bus.ifu_o_ready = 1'b1;
    do_reset(32'h8000_0000);
    tick();
    n_total++; if (s_req_v !== 1'b0) $display("FAIL boot_no_req: got %b expected 0", s_req_v); else n_pass++;
    repeat (8) tick();
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h8000_0000 + 32'(4 * i);
      n_total++;
      if (i >= req_log.size() || req_log[i] !== exp_pc) $display("FAIL boot_req_pc%0d: got %h expected %h", i, (i < req_log.size()) ? req_log[i] : 32'hx, exp_pc);
      else n_pass++;
    end
    n_total++; if (req_log.size() != 8) $display("FAIL boot_req_count: got %0d expected 8", req_log.size()); else n_pass++;
    n_total++; if (req_cyc[0] != 1) $display("FAIL boot_first_req_cycle: got %0d expected 1", req_cyc[0]); else n_pass++;
    n_total++; if (pop_cyc[0] - rsp_cyc[0] != 1) $display("FAIL boot_rsp_to_out_latency: got %0d expected 1", pop_cyc[0] - rsp_cyc[0]); else n_pass++;
    n_total++; if (pop_pc[0] !== 32'h8000_0000) $display("FAIL boot_o_pc: got %h expected 80000000", pop_pc[0]); else n_pass++;
    n_total++; if (pop_ir[0] !== mk_ir(32'h8000_0000)) $display("FAIL boot_o_ir: got %h expected %h", pop_ir[0], mk_ir(32'h8000_0000)); else n_pass++;
  endtask

  task automatic test_fill_stall();
    lat = 1; bus.ifu_o_ready = 1'b0;
    do_reset(32'h0000_0100);
    repeat (12) tick();
    n_total++; if (req_log.size() != 4) $display("FAIL fill_req_count: got %0d expected 4", req_log.size()); else n_pass++;
    n_total++; if (s_req_v !== 1'b0) $display("FAIL fill_req_blocked: got %b expected 0", s_req_v); else n_pass++;
    n_total++; if (bus.ifu_o_pc !== 32'h100) $display("FAIL fill_head_pc: got %h expected 00000100", bus.ifu_o_pc); else n_pass++;
    bus.ifu_o_ready = 1'b1;
    tick();
    bus.ifu_o_ready = 1'b0;
    n_total++; if (pop_pc.size() != 1) $display("FAIL fill_pop_count: got %0d expected 1", pop_pc.size()); else n_pass++;
    n_total++; if (bus.ifu_req_valid !== 1'b1) $display("FAIL fill_req_resume: got %b expected 1", bus.ifu_req_valid); else n_pass++;
    n_total++; if (bus.ifu_req_pc !== 32'h110) $display("FAIL fill_resume_pc: got %h expected 00000110", bus.ifu_req_pc); else n_pass++;
  endtask

  task automatic test_latency3();
    int bad;
    lat = 3; bus.ifu_o_ready = 1'b1;
    do_reset(32'h0000_2000);
    repeat (30) tick();
    n_total++; if (max_outs != 2) $display("FAIL lat3_max_outstanding: got %0d expected 2", max_outs); else n_pass++;
    n_total++; if (pop_pc.size() < 5) $display("FAIL lat3_pop_count: got %0d expected at least 5", pop_pc.size()); else n_pass++;
    n_total++; if (pop_pc[0] !== 32'h2000) $display("FAIL lat3_first_pc: got %h expected 00002000", pop_pc[0]); else n_pass++;
    bad = 0;
    for (int i = 1; i < pop_pc.size(); i++)
      if (pop_pc[i] !== pop_pc[i-1] + 32'd4 || pop_ir[i] !== mk_ir(pop_pc[i])) bad++;
    n_total++; if (bad != 0) $display("FAIL lat3_pc_stride: got %0d bad entries expected 0", bad); else n_pass++;
  endtask

  task automatic test_flush();
    lat = 3; bus.ifu_o_ready = 1'b1;
    do_reset(32'h0000_4000);
    repeat (3) tick();
    n_total++; if (outs_model != 2) $display("FAIL flush_setup_outs: got %0d expected 2", outs_model); else n_pass++;
    clear_logs();
    flush_req = 1'b1; flush_pc = 32'h0000_1002;
    tick();
    flush_req = 1'b0;
    n_total++; if (s_req_v !== 1'b0) $display("FAIL flush_cycle_req: got %b expected 0", s_req_v); else n_pass++;
    repeat (12) tick();
    n_total++; if (req_log[0] !== 32'h1000) $display("FAIL flush_next_req_pc: got %h expected 00001000", req_log[0]); else n_pass++;
    n_total++; if (req_cyc[0] != 5) $display("FAIL flush_next_req_cycle: got %0d expected 5", req_cyc[0]); else n_pass++;
    n_total++; if (pop_pc[0] !== 32'h1000) $display("FAIL flush_next_o_pc: got %h expected 00001000", pop_pc[0]); else n_pass++;
    n_total++; if (pop_ir[0] !== mk_ir(32'h1000)) $display("FAIL flush_next_o_ir: got %h expected %h", pop_ir[0], mk_ir(32'h1000)); else n_pass++;
    n_total++; if (pop_cyc[0] != 9) $display("FAIL flush_next_o_cycle: got %0d expected 9", pop_cyc[0]); else n_pass++;
  endtask

  task automatic test_flush_collide();
    lat = 1; bus.ifu_o_ready = 1'b0;
    do_reset(32'h0000_3000);
    repeat (3) tick();
    n_total++; if (bus.ifu_o_valid !== 1'b1) $display("FAIL collide_setup_o_valid: got %b expected 1", bus.ifu_o_valid); else n_pass++;
    clear_logs();
    flush_req = 1'b1; flush_pc = 32'h0000_5000;
    tick();
    flush_req = 1'b0;
    n_total++; if (s_o_v !== 1'b0) $display("FAIL collide_o_valid_forced: got %b expected 0", s_o_v); else n_pass++;
    n_total++; if (req_log.size() != 0) $display("FAIL collide_req_issued: got %0d expected 0", req_log.size()); else n_pass++;
    n_total++; if (bus.ifu_o_valid !== 1'b0) $display("FAIL collide_queue_cleared: got %b expected 0", bus.ifu_o_valid); else n_pass++;
    n_total++; if (bus.ifu_req_pc !== 32'h5000) $display("FAIL collide_req_pc: got %h expected 00005000", bus.ifu_req_pc); else n_pass++;
    halt_req = 1'b1;
    #1;
    n_total++; if (halt_ack !== 1'b1) $display("FAIL collide_outs_zero: got %b expected 1", halt_ack); else n_pass++;
    halt_req = 1'b0;
    bus.ifu_o_ready = 1'b1;
    repeat (6) tick();
    n_total++; if (pop_pc[0] !== 32'h5000) $display("FAIL collide_first_o_pc: got %h expected 00005000", pop_pc[0]); else n_pass++;
  endtask

  task automatic test_err_halt();
    int n;
    lat = 1; bus.ifu_o_ready = 1'b1; err_pc = 32'h0000_6004;
    do_reset(32'h0000_6000);
    repeat (8) tick();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (pop_pc[i] !== 32'h6000 + 32'(4 * i) || pop_err[i] !== (i == 1))
        $display("FAIL err_entry%0d: got pc %h err %b expected pc %h err %b", i, pop_pc[i], pop_err[i], 32'h6000 + 32'(4 * i), (i == 1));
      else n_pass++;
    end
    err_pc = 32'hFFFF_FFFF;
    lat = 3;
    do_reset(32'h0000_7000);
    repeat (3) tick();
    halt_req = 1'b1;
    clear_logs();
    #1;
    n_total++; if (halt_ack !== 1'b0) $display("FAIL halt_ack_early: got %b expected 0", halt_ack); else n_pass++;
    n = 0;
    while (halt_ack !== 1'b1 && n < 10) begin tick(); n++; end
    n_total++; if (n != 3) $display("FAIL halt_drain_cycles: got %0d expected 3", n); else n_pass++;
    n_total++; if (req_log.size() != 0) $display("FAIL halt_req_blocked: got %0d expected 0", req_log.size()); else n_pass++;
    n_total++; if (rsp_cyc.size() != 2) $display("FAIL halt_rsp_continue: got %0d expected 2", rsp_cyc.size()); else n_pass++;
    halt_req = 1'b0;
    #1;
    n_total++; if (bus.ifu_req_valid !== 1'b1) $display("FAIL halt_release_req: got %b expected 1", bus.ifu_req_valid); else n_pass++;
    n_total++; if (bus.ifu_req_pc !== 32'h7008) $display("FAIL halt_release_pc: got %h expected 00007008", bus.ifu_req_pc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_boot_seq();
    test_fill_stall();
    test_latency3();
    test_flush();
    test_flush_collide();
    test_err_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
